// File: rtl/audio_mem_scheduler_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared scheduler state encoding, memory geometry and mix helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int unsigned SLOT_DEPTH = 32000;
    localparam int unsigned ADDR_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD0  = 3'd2,
        ST_RD1  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    // Signed 8-bit add clamped to [-128, 127]; overflow shows as bit8 != bit7.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (!s[8] && s[7]) return 8'h7F;
        if (s[8] && !s[7]) return 8'h80;
        return s[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mem_scheduler_if.sv
// ============================================================================
// Module   : audio_mem_scheduler_if
// Purpose  : Single-port BRAM bus between the scheduler and the clip memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_mem_scheduler_if;
    logic [audio_pkg::ADDR_W-1:0] bram_addr_out;
    logic                         bram_we_out;
    logic [7:0]                   bram_din_out;
    logic [7:0]                   bram_dout_in;

    modport master (
        output bram_addr_out,
        output bram_we_out,
        output bram_din_out,
        input  bram_dout_in
    );

    modport slave (
        input  bram_addr_out,
        input  bram_we_out,
        input  bram_din_out,
        output bram_dout_in
    );
endinterface

`default_nettype wire

// File: rtl/audio_mem_scheduler_voice_ptr.sv
// ============================================================================
// Module   : audio_voice_ptr
// Purpose  : Per-voice playback read pointer with wrap and mute handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_voice_ptr
    import audio_pkg::*;
(
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    input  wire logic              play_in,
    input  wire logic              rec_busy_in,
    input  wire logic              adv_in,
    input  wire logic [ADDR_W-1:0] len_in,
    output logic      [ADDR_W-1:0] ptr_out,
    output logic                   mute_out
);

    logic              play_q, play_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] ptr_inc;

    always_comb begin
        mute_out = !play_in || (len_in == '0) || rec_busy_in;
        ptr_inc  = ptr_q + 1'b1;
        play_d   = play_in;
        ptr_d    = ptr_q;
        if (mute_out || !play_q) begin
            ptr_d = '0;
        end else if (adv_in) begin
            // >= rather than == so a shortened clip cannot strand the pointer
            ptr_d = (ptr_inc >= len_in) ? '0 : ptr_inc;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            play_q <= 1'b0;
            ptr_q  <= '0;
        end else begin
            play_q <= play_d;
            ptr_q  <= ptr_d;
        end
    end

    assign ptr_out = ptr_q;

endmodule

`default_nettype wire

// File: rtl/audio_mem_scheduler.sv
// ============================================================================
// Module   : audio_mem_scheduler
// Purpose  : Two-slot record / two-voice playback scheduler on one shared BRAM.
//            Define AUDIO_SCHED_MIX_EN to enable the saturating voice mix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_mem_scheduler
    import audio_pkg::ADDR_W;
    import audio_pkg::state_t;
    import audio_pkg::ST_IDLE;
    import audio_pkg::ST_WR;
    import audio_pkg::ST_RD0;
    import audio_pkg::ST_RD1;
    import audio_pkg::ST_WAIT;
#(
    parameter int unsigned DECIM      = 8,
    parameter int unsigned SLOT_DEPTH = audio_pkg::SLOT_DEPTH,
    parameter int unsigned RD_LAT     = 2
) (
    input  wire logic                   clk_in,
    input  wire logic                   rst_in,
    input  wire logic                   tick_in,
    input  wire logic                   rec_in,
    input  wire logic                   rec_slot_in,
    input  wire logic [7:0]             rec_data_in,
    input  wire logic [1:0]             play_in,
    audio_mem_scheduler_if.master       bram,
    output logic      [7:0]             voice0_out,
    output logic      [7:0]             voice1_out,
    output logic      [7:0]             mix_out,
    output logic                        sample_valid_out,
    output logic                        rec_full_out,
    output logic                        overrun_out
);

    localparam int unsigned       DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned       LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(SLOT_DEPTH);
    localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

    state_t                  state_q, state_d;
    logic [DEC_W-1:0]        dec_q, dec_d;
    logic                    stride_q, stride_d;
    logic [LAT_W-1:0]        wait_q, wait_d;
    logic [RD_LAT-1:0]       pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0]       pipe_voice_q, pipe_voice_d;
    logic [1:0][7:0]         hold_q, hold_d;
    logic                    rec_prev_q, rec_prev_d;
    logic                    rec_slot_q, rec_slot_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0][ADDR_W-1:0]  len_q, len_d;
    logic                    full_q, full_d;
    logic                    overrun_q, overrun_d;
    logic                    valid_q, valid_d;
    logic [7:0]              voice0_q, voice0_d;
    logic [7:0]              voice1_q, voice1_d;

    logic [1:0][ADDR_W-1:0]  rd_ptr;
    logic [1:0]              mute;
    logic [1:0]              rec_busy;
    logic                    rec_rise, rec_fall, rec_active;
    logic                    seq_done, wr_en, adv;

    assign rec_rise   = rec_in && !rec_prev_q;
    assign rec_fall   = !rec_in && rec_prev_q;
    assign rec_active = rec_in && rec_prev_q;
    assign rec_busy   = {rec_active && rec_slot_q, rec_active && !rec_slot_q};
    assign seq_done   = (state_q == ST_WAIT) && (wait_q == LAT_LAST);
    assign adv        = seq_done && stride_q;
    // Gating with reset keeps a sequence caught mid-WR from corrupting memory.
    assign wr_en      = (state_q == ST_WR) && rec_active && stride_q &&
                        (wr_ptr_q < DEPTH_A) && !rst_in;

    for (genvar v = 0; v < 2; v++) begin : g_voice
        audio_voice_ptr u_ptr (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .play_in     (play_in[v]),
            .rec_busy_in (rec_busy[v]),
            .adv_in      (adv),
            .len_in      (len_q[v]),
            .ptr_out     (rd_ptr[v]),
            .mute_out    (mute[v])
        );
    end

    always_comb begin
        bram.bram_addr_out = '0;
        bram.bram_we_out   = 1'b0;
        bram.bram_din_out  = '0;
        case (state_q)
            ST_WR: begin
                bram.bram_addr_out = (rec_slot_q ? DEPTH_A : '0) + wr_ptr_q;
                bram.bram_we_out   = wr_en;
                bram.bram_din_out  = rec_data_in;
            end
            ST_RD0:  bram.bram_addr_out = rd_ptr[0];
            ST_RD1:  bram.bram_addr_out = DEPTH_A + rd_ptr[1];
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        dec_d    = dec_q;
        stride_d = stride_q;
        case (state_q)
            ST_IDLE: if (tick_in) begin
                state_d  = ST_WR;
                stride_d = (dec_q == DEC_LAST);
                dec_d    = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
            end
            ST_WR:   state_d = ST_RD0;
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_q == LAT_LAST) state_d = ST_IDLE;
                else                    wait_d  = wait_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read tags ride alongside the BRAM latency so data lands in the right voice.
    always_comb begin
        pipe_vld_d[0]   = (state_q == ST_RD0) || (state_q == ST_RD1);
        pipe_voice_d[0] = (state_q == ST_RD1);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]   = pipe_vld_q[i-1];
            pipe_voice_d[i] = pipe_voice_q[i-1];
        end
        hold_d = hold_q;
        if (pipe_vld_q[RD_LAT-1]) hold_d[pipe_voice_q[RD_LAT-1]] = bram.bram_dout_in;
        valid_d  = seq_done;
        voice0_d = voice0_q;
        voice1_d = voice1_q;
        if (seq_done) begin
            voice0_d = mute[0] ? '0 : hold_d[0];
            voice1_d = mute[1] ? '0 : hold_d[1];
        end
    end

    always_comb begin
        rec_prev_d = rec_in;
        rec_slot_d = rec_slot_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        full_d     = full_q;
        if (rec_rise) begin
            rec_slot_d         = rec_slot_in;
            wr_ptr_d           = '0;
            len_d[rec_slot_in] = '0;
            full_d             = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d          = wr_ptr_q + 1'b1;
                len_d[rec_slot_q] = wr_ptr_q + 1'b1;
                if (wr_ptr_q + 1'b1 == DEPTH_A) full_d = 1'b1;
            end
            if (rec_fall) len_d[rec_slot_q] = wr_ptr_q;
        end
        overrun_d = overrun_q || (tick_in && (state_q != ST_IDLE));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            dec_q        <= '0;
            stride_q     <= 1'b0;
            wait_q       <= '0;
            pipe_vld_q   <= '0;
            pipe_voice_q <= '0;
            hold_q       <= '0;
            rec_prev_q   <= 1'b0;
            rec_slot_q   <= 1'b0;
            wr_ptr_q     <= '0;
            len_q        <= '0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
            valid_q      <= 1'b0;
            voice0_q     <= '0;
            voice1_q     <= '0;
        end else begin
            state_q      <= state_d;
            dec_q        <= dec_d;
            stride_q     <= stride_d;
            wait_q       <= wait_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_voice_q <= pipe_voice_d;
            hold_q       <= hold_d;
            rec_prev_q   <= rec_prev_d;
            rec_slot_q   <= rec_slot_d;
            wr_ptr_q     <= wr_ptr_d;
            len_q        <= len_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
            valid_q      <= valid_d;
            voice0_q     <= voice0_d;
            voice1_q     <= voice1_d;
        end
    end

`ifdef AUDIO_SCHED_MIX_EN
    logic [7:0] mix_q, mix_d;

    always_comb begin
        mix_d = mix_q;
        if (seq_done) mix_d = audio_pkg::sat_add8(voice0_d, voice1_d);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    assign mix_out = mix_q;
`else
    assign mix_out = '0;
`endif

    assign voice0_out       = voice0_q;
    assign voice1_out       = voice1_q;
    assign sample_valid_out = valid_q;
    assign rec_full_out     = full_q;
    assign overrun_out      = overrun_q;

endmodule

`default_nettype wire
